// File: rtl/fns_ftf_encoder_iter.sv
// fns_ftf_encoder_iter
//   Multi-cycle Fibonacci-numeral-system (FNS) forbidden-transition-free encoder.
//   A word is accepted in IDLE. RUN then resolves BPC codeword bits per clock,
//   from the MSB downwards. DONE presents the registered codeword until the
//   consumer takes it.
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_data is the binary value to encode
//   out_valid / out_ready output handshake
//   out_code              codeword; bit i has weight F(i+1)
//   out_err               in_data was >= F(CODE_W+2); out_code is 0 in that case
module fns_ftf_encoder_iter #(
  parameter int   CODE_W = 16,
  parameter int   BPC    = 4,
  parameter int   DATA_W = 12,
  parameter logic SEED   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_err
);

  // Compare width: wide enough for both the data path and every Fibonacci
  // constant that is actually indexed (at most F(34) for a 32-bit code).
  localparam int FW = (DATA_W > 32 ? DATA_W : 32) + 1;
  // Bit-pointer width. The table covers every pointer value, so any index
  // (including pointer+2) stays inside the array.
  localparam int PW = $clog2(CODE_W + 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [63:0] fib(input int k);
    logic [63:0] a, b, t;
    a = 64'd1;
    b = 64'd1;
    if (k <= 0) return 64'd0;
    if (k <= 2) return 64'd1;
    for (int x = 3; x <= k; x++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  logic [FW-1:0] fib_w [0:(1<<PW)-1];

  genvar g;
  generate
    for (g = 0; g < (1 << PW); g++) begin : g_fib
      assign fib_w[g] = FW'(fib(g));
    end
  endgenerate

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   r_q, r_d;
  logic [PW-1:0]       p_q, p_d;
  logic                prev_q, prev_d;
  logic [CODE_W-1:0]   work_q, work_d;   // bits resolved so far, never driven out
  logic [CODE_W-1:0]   code_q, code_d;
  logic                err_q, err_d;

  logic                in_range;

  // One RUN cycle: BPC chained stages starting at bit p_q
  logic [DATA_W-1:0]   r_c;
  logic                prev_c;
  logic [CODE_W-1:0]   bits_c;
  logic                b_c;
  logic [PW-1:0]       idx, idx1, idx2;
  logic [FW-1:0]       rw;

  assign in_range = FW'(in_data) < fib_w[CODE_W+2];

  always_comb begin
    r_c    = r_q;
    prev_c = prev_q;
    bits_c = work_q;
    b_c    = 1'b0;
    idx    = '0;
    idx1   = '0;
    idx2   = '0;
    rw     = '0;
    for (int j = 0; j < BPC; j++) begin
      idx  = p_q - PW'(j);
      idx1 = idx + PW'(1);
      idx2 = idx + PW'(2);
      rw   = FW'(r_c);
      if (idx == '0) begin
        // The remainder is already 0 or 1 here, so it is the LSB itself.
        b_c = r_c[0];
      end else begin
        if (rw < fib_w[idx1])       b_c = 1'b0;
        else if (rw >= fib_w[idx2]) b_c = 1'b1;
        else                        b_c = prev_c;  // ambiguous band: repeat the bit above
        if (b_c) r_c = r_c - DATA_W'(fib_w[idx1]);
      end
      bits_c = bits_c | (CODE_W'(b_c) << idx);
      prev_c = b_c;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    prev_d  = prev_q;
    work_d  = work_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_range) begin
            state_d = S_RUN;
            r_d     = in_data;
            p_d     = PW'(CODE_W - 1);
            prev_d  = SEED;
            work_d  = '0;
          end else begin
            state_d = S_DONE;
            code_d  = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        r_d    = r_c;
        prev_d = prev_c;
        work_d = bits_c;
        p_d    = p_q - PW'(BPC);
        // Last group ends at bit 0, which means the pointer was BPC-1.
        if (p_q == PW'(BPC - 1)) begin
          state_d = S_DONE;
          code_d  = bits_c;
          err_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      p_q     <= '0;
      prev_q  <= 1'b0;
      work_q  <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      p_q     <= p_d;
      prev_q  <= prev_d;
      work_q  <= work_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  // in_ready is masked while reset is asserted so every output reads 0 then.
  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_DONE);
  assign out_code  = code_q;
  assign out_err   = err_q;

endmodule
